// File: rtl/alu_pkg.sv
// Shared ALU control constants and the issue-stage buffer entry type.
package alu_pkg;

    localparam int unsigned ALU_DATA_W = 64;
    localparam int unsigned ALU_OPC_W  = 11;

    // ALU select encodings
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    // ALUOp from main control
    typedef enum logic [1:0] {
        AluOpLdSt  = 2'b00,
        AluOpCbz   = 2'b01,
        AluOpRType = 2'b10,
        AluOpRsvd  = 2'b11
    } alu_op_e;

    // R-type opcode field, instr[31:21]
    localparam logic [10:0] OPC_ADD = 11'b10001011000;
    localparam logic [10:0] OPC_SUB = 11'b11001011000;
    localparam logic [10:0] OPC_AND = 11'b10001010000;
    localparam logic [10:0] OPC_ORR = 11'b10101010000;

    typedef struct packed {
        logic [3:0]            select;
        logic                  illegal;
        logic [ALU_DATA_W-1:0] input1;
        logic [ALU_DATA_W-1:0] input2;
    } issue_entry_t;

endpackage

// File: rtl/alu_issue_stage_if.sv
// Upstream (decode) and downstream (ALU) handshake bundle of the ALU issue stage.
interface alu_issue_stage_if #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned OPC_W  = 11
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_alu_op;
    logic [OPC_W-1:0]  in_opcode;
    logic [DATA_W-1:0] in_rs1;
    logic [DATA_W-1:0] in_rs2;
    logic [DATA_W-1:0] in_imm;
    logic              in_use_imm;
    logic              out_valid;
    logic              out_ready;
    logic [3:0]        select;
    logic [DATA_W-1:0] input1;
    logic [DATA_W-1:0] input2;
    logic              illegal;

    // Environment side: presents ops, consumes ALU outputs
    modport master (
        output in_valid, in_alu_op, in_opcode, in_rs1, in_rs2, in_imm, in_use_imm, out_ready,
        input  in_ready, out_valid, select, input1, input2, illegal
    );

    // Issue stage side
    modport slave (
        input  in_valid, in_alu_op, in_opcode, in_rs1, in_rs2, in_imm, in_use_imm, out_ready,
        output in_ready, out_valid, select, input1, input2, illegal
    );
endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational LEGv8 ALU control: (ALUOp, opcode) -> 4-bit ALU select plus illegal flag.
module alu_ctrl_decode
    import alu_pkg::*;
#(
    parameter int unsigned OPC_W = ALU_OPC_W
) (
    input  logic [1:0]       alu_op,
    input  logic [OPC_W-1:0] opcode,
    output logic [3:0]       select,
    output logic             illegal
);

    always_comb begin
        select  = ALU_AND;
        illegal = 1'b0;
        unique case (alu_op_e'(alu_op))
            AluOpLdSt: select = ALU_ADD;
            AluOpCbz:  select = ALU_SUB;
            AluOpRType: begin
                if (opcode == OPC_W'(OPC_ADD)) begin
                    select = ALU_ADD;
                end else if (opcode == OPC_W'(OPC_SUB)) begin
                    select = ALU_SUB;
                end else if (opcode == OPC_W'(OPC_AND)) begin
                    select = ALU_AND;
                end else if (opcode == OPC_W'(OPC_ORR)) begin
                    select = ALU_OR;
                end else begin
                    illegal = 1'b1;
                end
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes ALU control and registers operands through a 2-entry skid buffer.
// Optional build macro ALU_ISSUE_ILLEGAL_DROP_EN: drop illegal ops and flag them on illegal_seen.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = ALU_DATA_W,
    parameter int unsigned OPC_W  = ALU_OPC_W
) (
    input  logic              clk,
    input  logic              rst,
    alu_issue_stage_if.slave  bus
`ifdef ALU_ISSUE_ILLEGAL_DROP_EN
    ,
    output logic              illegal_seen
`endif
);

    logic [3:0]        dec_select;
    logic              dec_illegal;
    logic [DATA_W-1:0] op_b;
    issue_entry_t      new_entry;

    issue_entry_t main_q, main_d;
    issue_entry_t skid_q, skid_d;
    logic         main_valid_q, main_valid_d;
    logic         skid_valid_q, skid_valid_d;
    logic         in_ready_q, in_ready_d;

    logic accept, xfer, write;

    alu_ctrl_decode #(
        .OPC_W (OPC_W)
    ) u_decode (
        .alu_op  (bus.in_alu_op),
        .opcode  (bus.in_opcode),
        .select  (dec_select),
        .illegal (dec_illegal)
    );

    assign op_b = bus.in_use_imm ? bus.in_imm : bus.in_rs2;

    always_comb begin
        new_entry         = '0;
        new_entry.select  = dec_select;
        new_entry.illegal = dec_illegal;
        new_entry.input1  = bus.in_rs1;
        new_entry.input2  = op_b;
    end

    assign accept = bus.in_valid && in_ready_q;
    assign xfer   = main_valid_q && bus.out_ready;

`ifdef ALU_ISSUE_ILLEGAL_DROP_EN
    // Illegal ops complete the input handshake but never occupy storage
    assign write = accept && !dec_illegal;
`else
    assign write = accept;
`endif

    // Drain first, then fill the lowest free slot: keeps ONE->ONE at full throughput
    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (xfer) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end else begin
                main_valid_d = 1'b0;
            end
        end
        if (write) begin
            if (!main_valid_d) begin
                main_d       = new_entry;
                main_valid_d = 1'b1;
            end else begin
                skid_d       = new_entry;
                skid_valid_d = 1'b1;
            end
        end
        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

`ifdef ALU_ISSUE_ILLEGAL_DROP_EN
    logic illegal_seen_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_seen_q <= 1'b0;
        end else if (accept && dec_illegal) begin
            illegal_seen_q <= 1'b1;
        end
    end

    assign illegal_seen = illegal_seen_q;
    assign bus.illegal  = 1'b0;
`else
    assign bus.illegal  = main_q.illegal;
`endif

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = main_valid_q;
    assign bus.select    = main_q.select;
    assign bus.input1    = main_q.input1;
    assign bus.input2    = main_q.input2;

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Pipeline stage directly upstream of the 64-bit ALU: registers decoded operands and turns LEGv8 ALUOp plus the opcode field into the ALU's 4-bit select.
- Valid/ready handshake on both sides; 2-entry skid buffer so in_ready is a pure register output.
- Outputs (select, input1, input2) drive the ALU ports of the same names directly.

Parameters:
- DATA_W, 64, operand width; must match ALU width
- OPC_W, 11, R-type opcode field width (instr[31:21])

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  decode presents an op
- in_ready  out  1  stage can accept; registered
- in_alu_op  in  2  ALUOp from main control
- in_opcode  in  OPC_W  instr[31:21]
- in_rs1  in  DATA_W  register-file read data 1
- in_rs2  in  DATA_W  register-file read data 2
- in_imm  in  DATA_W  sign-extended immediate
- in_use_imm  in  1  1: input2 = in_imm, else in_rs2
- out_valid  out  1  op valid toward ALU
- out_ready  in  1  ALU/EX consumes op this cycle
- select  out  4  ALU select
- input1  out  DATA_W  ALU operand A
- input2  out  DATA_W  ALU operand B
- illegal  out  1  current output op has no legal decode

Behaviour:
- Reset (async, asserted): out_valid=0, in_ready=1, select=4'b0000, input1=0, input2=0, illegal=0; both buffer entries invalid. No partial state survives a mid-operation reset; first accept after release behaves as from empty.
- Accept when in_valid && in_ready; output transfer when out_valid && out_ready.
- Decode (combinational on input, registered with the entry):
  - alu_op 00 -> 0010 (load/store address add)
  - alu_op 01 -> 0110 (CBZ compare subtract)
  - alu_op 10 with opcode 10001011000 -> 0010 ADD; 11001011000 -> 0110 SUB; 10001010000 -> 0000 AND; 10101010000 -> 0001 ORR
  - alu_op 10 with any other opcode, or alu_op 11 -> illegal=1, select=0000
- input1=in_rs1; input2 = in_use_imm ? in_imm : in_rs2; stored unmodified.
- Storage: main entry (drives outputs) + skid entry.
  - EMPTY: accept -> main, out_valid=1 next cycle (latency 1).
  - ONE: simultaneous transfer+accept -> main replaced, stays ONE (full throughput). Accept without transfer -> skid, FULL. Transfer without accept -> EMPTY.
  - FULL: in_ready=0. Transfer -> skid moves to main, ONE.
- in_ready = !skid_valid, registered; never depends combinationally on out_ready.
- Ordering strictly FIFO; no op dropped or duplicated except as specified under the optional feature.
- Outputs held stable while out_valid && !out_ready.
- in_* ignored when in_ready=0 or in_valid=0.

Optional Feature:
- Macro ALU_ISSUE_ILLEGAL_DROP_EN.
- Defined: illegal ops are accepted but never written into storage (no out_valid); sticky output illegal_seen (1 bit, reset 0) sets on such an accept; `illegal` output tied 0.
- Undefined: illegal ops flow through with select=0000, illegal=1; no illegal_seen port.

Decomposition:
- Package alu_pkg: ALU select constants (ALU_AND=0000, ALU_OR=0001, ALU_ADD=0010, ALU_SUB=0110), ALUOp encodings, the four R-type opcode constants, and a packed struct for one buffer entry (select, illegal, input1, input2).
- Sub-module alu_ctrl_decode: purely combinational (alu_op, opcode) -> (select, illegal); reused by later stages.

Test Plan:
- Reset while FULL -> next cycle out_valid=0, in_ready=1, select=0, input1=input2=0; then ADD rs1=5, rs2=3 accepted -> one cycle later select=0010, input1=5, input2=3.
- alu_op=10, opcode 11001011000, use_imm=1, imm=64'hFFFF_FFFF_FFFF_FFFF -> select=0110, input2=all ones, illegal=0.
- Back-to-back 8 ops with out_ready=1 -> 8 transfers in 8 consecutive cycles, in order, in_ready stays 1.
- out_ready=0 with 3 ops offered -> first two accepted, in_ready=0 the cycle after the second accept; outputs hold op0. Raise out_ready -> op0, op1, op2 delivered in order.
- alu_op=11 -> without macro: illegal=1, select=0000 delivered. With ALU_ISSUE_ILLEGAL_DROP_EN: no out_valid, illegal_seen=1 until reset.
- Each R-type opcode plus alu_op 00/01 -> select matches the mapping table exactly.
